key_event_decoder: RTL and testbench

Consumes the debounced key level produced by the key debounce stage and turns it into one-cycle event pulses: press, release, long-press, auto-repeat, single-click and double-click. It sits between the debouncer's `Pin_Out` and the application logic (PWM duty stepping, mode selection). It runs entirely in the 50 MHz system clock domain and uses a 1 ms time base derived internally.

---
 rtl/key_pkg.sv | 26 ++
 rtl/ms_tick_gen.sv | 34 +++
 rtl/key_event_decoder.sv | 143 ++++++++++++++
 tb/tb_key_event_decoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared encodings and default timing for the key event decoder.
// Expiry is flagged on the tick that would advance Count_MS to the limit, so intervals are exact.
package key_pkg;

    localparam int MS_W = 11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HOLD  = 3'd1;
    localparam logic [2:0] ST_DHOLD = 3'd2;
    localparam logic [2:0] ST_LONG  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [15:0]     T1MS_50M      = 16'd49_999;
    localparam logic [MS_W-1:0] LONG_MS_DEF   = 11'd1000;
    localparam logic [MS_W-1:0] REPEAT_MS_DEF = 11'd200;
    localparam logic [MS_W-1:0] DBL_MS_DEF    = 11'd300;

    localparam logic [MS_W-1:0] MS_ONE = 11'd1;

    function automatic logic interval_done(input logic            tick,
                                           input logic [MS_W-1:0] count_ms,
                                           input logic [MS_W-1:0] limit);
        return tick && (count_ms == (limit - MS_ONE));
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// 1 ms time base: Count1 prescales CLOCK, Count_MS counts elapsed milliseconds.
// Clear restarts both so every timed interval begins at zero.
module ms_tick_gen
    import key_pkg::*;
#(
    parameter logic [15:0] T1MS = T1MS_50M
)(
    input  logic            CLOCK,
    input  logic            RST_n,
    input  logic            Clear,
    output logic            Tick,
    output logic [MS_W-1:0] Count_MS
);

    logic [15:0] count1;

    assign Tick = (count1 == T1MS);

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            count1   <= 16'd0;
            Count_MS <= '0;
        end else if (Clear) begin
            count1   <= 16'd0;
            Count_MS <= '0;
        end else if (Tick) begin
            count1   <= 16'd0;
            Count_MS <= Count_MS + MS_ONE;
        end else begin
            count1   <= count1 + 16'd1;
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// Turns the debounced key level into one-cycle press/release/long/repeat/click/double pulses.
// Long_Sig lands exactly LONG_MS*(T1MS+1) clocks after Press_Sig (zero offset).
//   state | meaning
//   IDLE  | key up, no pending click
//   HOLD  | first press held, timing toward long-press
//   GAP   | released after short press, waiting for a second press
//   DHOLD | second press of a double-click held
//   LONG  | long-press active, emitting repeats
module key_event_decoder
    import key_pkg::*;
#(
    parameter logic [15:0]     T1MS      = T1MS_50M,
    parameter logic [MS_W-1:0] LONG_MS   = LONG_MS_DEF,
    parameter logic [MS_W-1:0] REPEAT_MS = REPEAT_MS_DEF,
    parameter logic [MS_W-1:0] DBL_MS    = DBL_MS_DEF
)(
    input  logic CLOCK,
    input  logic RST_n,
    input  logic Key_In,
    output logic Press_Sig,
    output logic Release_Sig,
    output logic Long_Sig,
    output logic Repeat_Sig,
    output logic Click_Sig,
    output logic Double_Sig
);

    logic            F1, F2;
    logic            rise, fall;
    logic [2:0]      state, state_nx;
    logic            clear, tick;
    logic [MS_W-1:0] count_ms;
    logic            long_done, rep_done, dbl_done;
    logic            press_nx, release_nx, long_nx, repeat_nx, click_nx, double_nx;

    ms_tick_gen #(.T1MS(T1MS)) u_ms_tick_gen (
        .CLOCK    (CLOCK),
        .RST_n    (RST_n),
        .Clear    (clear),
        .Tick     (tick),
        .Count_MS (count_ms)
    );

    assign rise      = F1 & ~F2;
    assign fall      = ~F1 & F2;
    assign long_done = interval_done(tick, count_ms, LONG_MS);
    assign rep_done  = interval_done(tick, count_ms, REPEAT_MS);
    assign dbl_done  = interval_done(tick, count_ms, DBL_MS);

    // Edges are tested before expiries so an edge wins a same-cycle tie.
    always_comb begin
        state_nx   = state;
        clear      = 1'b0;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        long_nx    = 1'b0;
        repeat_nx  = 1'b0;
        click_nx   = 1'b0;
        double_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                clear = 1'b1;
                if (rise) begin
                    state_nx = ST_HOLD;
                    press_nx = 1'b1;
                end
            end
            ST_HOLD: begin
                if (fall) begin
                    state_nx   = ST_GAP;
                    release_nx = 1'b1;
                    clear      = 1'b1;
                end else if (long_done) begin
                    state_nx = ST_LONG;
                    long_nx  = 1'b1;
                    clear    = 1'b1;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    state_nx  = ST_DHOLD;
                    press_nx  = 1'b1;
                    double_nx = 1'b1;
                    clear     = 1'b1;
                end else if (dbl_done) begin
                    state_nx = ST_IDLE;
                    click_nx = 1'b1;
                    clear    = 1'b1;
                end
            end
            ST_DHOLD: begin
                if (fall) begin
                    state_nx   = ST_IDLE;
                    release_nx = 1'b1;
                    clear      = 1'b1;
                end else if (long_done) begin
                    state_nx = ST_LONG;
                    long_nx  = 1'b1;
                    clear    = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_nx   = ST_IDLE;
                    release_nx = 1'b1;
                    clear      = 1'b1;
                end else if (rep_done) begin
                    repeat_nx = 1'b1;
                    clear     = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                clear    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            F1          <= 1'b0;
            F2          <= 1'b0;
            state       <= ST_IDLE;
            Press_Sig   <= 1'b0;
            Release_Sig <= 1'b0;
            Long_Sig    <= 1'b0;
            Repeat_Sig  <= 1'b0;
            Click_Sig   <= 1'b0;
            Double_Sig  <= 1'b0;
        end else begin
            F1          <= Key_In;
            F2          <= F1;
            state       <= state_nx;
            Press_Sig   <= press_nx;
            Release_Sig <= release_nx;
            Long_Sig    <= long_nx;
            Repeat_Sig  <= repeat_nx;
            Click_Sig   <= click_nx;
            Double_Sig  <= double_nx;
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: stimulus queues expected pulses with their cycle,
// a negedge monitor pops and compares whenever any output pulses.
module tb_key_event_decoder;

    logic CLOCK = 1'b0;
    logic RST_n = 1'b0;
    logic Key_In = 1'b0;
    logic Press_Sig, Release_Sig, Long_Sig, Repeat_Sig, Click_Sig, Double_Sig;
    logic [5:0] obs;

    localparam logic [5:0] EV_P = 6'b100000;
    localparam logic [5:0] EV_R = 6'b010000;
    localparam logic [5:0] EV_L = 6'b001000;
    localparam logic [5:0] EV_T = 6'b000100;
    localparam logic [5:0] EV_C = 6'b000010;
    localparam logic [5:0] EV_D = 6'b000001;

    key_event_decoder #(
        .T1MS      (16'd9),
        .LONG_MS   (11'd5),
        .REPEAT_MS (11'd2),
        .DBL_MS    (11'd3)
    ) dut (
        .CLOCK       (CLOCK),
        .RST_n       (RST_n),
        .Key_In      (Key_In),
        .Press_Sig   (Press_Sig),
        .Release_Sig (Release_Sig),
        .Long_Sig    (Long_Sig),
        .Repeat_Sig  (Repeat_Sig),
        .Click_Sig   (Click_Sig),
        .Double_Sig  (Double_Sig)
    );

    assign obs = {Press_Sig, Release_Sig, Long_Sig, Repeat_Sig, Click_Sig, Double_Sig};

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [5:0] ev;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;

    task automatic expect_ev(input int at, input logic [5:0] ev);
        q.push_back('{at: at, ev: ev});
    endtask

    // Drive Key_In at a negedge; t0 is the cycle number of the edge that samples it.
    task automatic set_key(input logic v, output int t0);
        @(negedge CLOCK);
        Key_In = v;
        t0 = cyc + 1;
    endtask

    task automatic hold(input int n);
        repeat (n - 1) @(negedge CLOCK);
    endtask

    always @(negedge CLOCK) begin
        exp_t e;
        if (!RST_n) begin
            n_tests++;
            if (obs != 6'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle=%0d got=%b want=000000", cyc, obs);
            end
        end else if (obs != 6'b0) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cycle=%0d got=%b want=none", cyc, obs);
            end else begin
                e = q.pop_front();
                if (e.at != cyc || e.ev != obs) begin
                    n_fail++;
                    $display("FAIL event cycle=%0d got=%b want cycle=%0d ev=%b",
                             cyc, obs, e.at, e.ev);
                end
            end
        end
        if (done) begin
            n_tests++;
            if (q.size() != 0) begin
                n_fail++;
                $display("FAIL missing_events got=%0d pending want=0 (next cycle=%0d ev=%b)",
                         q.size(), q[0].at, q[0].ev);
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        int a, b, c, d, e0;
        RST_n  = 1'b0;
        Key_In = 1'b0;
        repeat (3) @(negedge CLOCK);
        RST_n = 1'b1;
        repeat (5) @(negedge CLOCK);

        // short click
        set_key(1'b1, a); expect_ev(a + 1, EV_P);
        hold(20);
        set_key(1'b0, b); expect_ev(b + 1, EV_R); expect_ev(b + 31, EV_C);
        hold(50);

        // double click
        set_key(1'b1, a); expect_ev(a + 1, EV_P);
        hold(20);
        set_key(1'b0, b); expect_ev(b + 1, EV_R);
        hold(10);
        set_key(1'b1, c); expect_ev(c + 1, EV_P | EV_D);
        hold(20);
        set_key(1'b0, d); expect_ev(d + 1, EV_R);
        hold(50);

        // long press with repeats
        set_key(1'b1, a);
        expect_ev(a + 1, EV_P);
        expect_ev(a + 51, EV_L);
        expect_ev(a + 71, EV_T);
        expect_ev(a + 91, EV_T);
        expect_ev(a + 111, EV_T);
        hold(120);
        set_key(1'b0, b); expect_ev(b + 1, EV_R);
        hold(50);

        // fall on the long expiry cycle, then rise on the gap expiry cycle
        set_key(1'b1, a); expect_ev(a + 1, EV_P);
        hold(50);
        set_key(1'b0, b); expect_ev(b + 1, EV_R);
        hold(30);
        set_key(1'b1, c); expect_ev(c + 1, EV_P | EV_D);
        hold(20);
        set_key(1'b0, d); expect_ev(d + 1, EV_R);
        hold(50);

        // reset lands while a repeat pulse is high; key held through reset
        set_key(1'b1, a);
        expect_ev(a + 1, EV_P);
        expect_ev(a + 51, EV_L);
        while (cyc != a + 70) @(negedge CLOCK);
        @(posedge CLOCK);
        #1 RST_n = 1'b0;
        repeat (3) @(negedge CLOCK);
        RST_n = 1'b1;
        e0 = cyc + 1;
        expect_ev(e0 + 1, EV_P);
        expect_ev(e0 + 51, EV_L);
        repeat (59) @(negedge CLOCK);
        set_key(1'b0, b); expect_ev(b + 1, EV_R);
        hold(50);

        // gap expires into a click, then a plain press
        set_key(1'b1, a); expect_ev(a + 1, EV_P);
        hold(20);
        set_key(1'b0, b); expect_ev(b + 1, EV_R); expect_ev(b + 31, EV_C);
        hold(40);
        set_key(1'b1, c); expect_ev(c + 1, EV_P);
        hold(20);
        set_key(1'b0, d); expect_ev(d + 1, EV_R); expect_ev(d + 31, EV_C);
        hold(50);

        done = 1'b1;
    end

endmodule
